// File: rtl/grayscale_stream_if.sv
// Pixel FIFO handshake bundle: RGB read side and gray write side.
// master = converter, slave = FIFOs around it.
interface grayscale_stream_if;
  logic        in_rd_en;
  logic [23:0] in_dout;
  logic        in_empty;
  logic        out_wr_en;
  logic [7:0]  out_din;
  logic        out_full;

  modport master (
    output in_rd_en,
    output out_wr_en,
    output out_din,
    input  in_dout,
    input  in_empty,
    input  out_full
  );

  modport slave (
    input  in_rd_en,
    input  out_wr_en,
    input  out_din,
    output in_dout,
    output in_empty,
    output out_full
  );
endinterface

// File: rtl/grayscale_stream.sv
// RGB-to-luma converter feeding the Sobel gray FIFO.
// Two-state read/write loop with raster x/y tracking.
module grayscale_stream #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                clock,
  input  logic                reset,
  grayscale_stream_if.master  bus,
  output logic                frame_done
);

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam logic [12:0] X_LAST = 13'(IMG_WIDTH - 1);
  localparam logic [12:0] Y_LAST = 13'(IMG_HEIGHT - 1);

  state_t      state;
  state_t      state_n;
  logic [7:0]  gray;
  logic [12:0] x;
  logic [12:0] y;
  logic [15:0] luma_sum;
  logic        rd_en;
  logic        wr_en;

  // Weighted luma sum; weights total 256 so 16 bits never overflow.
  always_comb begin
    luma_sum = 16'd77  * {8'd0, bus.in_dout[23:16]}
             + 16'd150 * {8'd0, bus.in_dout[15:8]}
             + 16'd29  * {8'd0, bus.in_dout[7:0]};
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_READ;
    end else begin
      state <= state_n;
    end
  end

  // Next state and FIFO strobes; strobes are held off during reset.
  always_comb begin
    state_n     = state;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    bus.out_din = gray;
    unique case (state)
      S_READ: begin
        if (!bus.in_empty && !reset) begin
          rd_en   = 1'b1;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!bus.out_full && !reset) begin
          wr_en   = 1'b1;
          state_n = S_READ;
        end
      end
      default: state_n = S_READ;
    endcase
  end

  assign bus.in_rd_en  = rd_en;
  assign bus.out_wr_en = wr_en;

  // Capture the floored luma of the pixel being read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gray <= 8'd0;
    end else if (rd_en) begin
      gray <= luma_sum[15:8];
    end
  end

  // Raster position; frame_done pulses after the last pixel is written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x          <= 13'd0;
      y          <= 13'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_en) begin
        if (x == X_LAST) begin
          x <= 13'd0;
          if (y == Y_LAST) begin
            y          <= 13'd0;
            frame_done <= 1'b1;
          end else begin
            y <= y + 13'd1;
          end
        end else begin
          x <= x + 13'd1;
        end
      end
    end
  end

endmodule
